shift_arbiter: RTL and testbench

//  Shares one instance of the 32-bit right-shift datapath (shift_right) between two

---
 rtl/shift_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_shift_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin front end for a shared 32-bit
// right shifter. SRL/SRA/SLL are all mapped onto the right shifter; the result
// is held in a one-deep output stage with valid/ready backpressure.
// Optional build macro: SHIFT_ARB_STATS_EN adds grant/stall statistics counters.

// Logarithmic right shifter with a programmable fill bit.
module shift_right #(
  parameter int unsigned W    = 32,
  parameter int unsigned SH_W = $clog2(W)
) (
  input  logic [W-1:0]    i_b,
  input  logic            i_ir,
  input  logic [SH_W-1:0] i_shamt,
  output logic [W-1:0]    o_h
);

  logic [W-1:0] w_stage [0:SH_W];

  assign w_stage[0] = i_b;

  // Stage k shifts by 2**k when shamt bit k is set, filling from the top with IR.
  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    localparam int unsigned AMT = 2 ** k;
    assign w_stage[k+1] = i_shamt[k] ? {{AMT{i_ir}}, w_stage[k][W-1:AMT]}
                                     : w_stage[k];
  end

  assign o_h = w_stage[SH_W];

endmodule

module shift_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [3:0]                    req_op,
  input  logic [2*DATA_W-1:0]           req_data,
  input  logic [2*$clog2(DATA_W)-1:0]   req_shamt,
  input  logic [2*TAG_W-1:0]            req_tag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_id,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic                          rsp_err
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_grant0,
  output logic [15:0]                   stat_grant1,
  output logic [15:0]                   stat_stall
`endif
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic [0:0]        r_state;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_id;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic              r_rsp_err;

  logic              w_gnt;
  logic              w_can_accept;
  logic              w_accept;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_data_rev;
  logic [SH_W-1:0]   w_shamt;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_sh_b;
  logic              w_sh_ir;
  logic [DATA_W-1:0] w_sh_h;
  logic [DATA_W-1:0] w_sh_h_rev;
  logic [DATA_W-1:0] w_result;
  logic              w_err;

  // Round-robin pick: with both requesting, the one not granted last wins.
  always_comb begin
    w_gnt = 1'b0;
    case (req_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last_grant;
      default: w_gnt = 1'b0;
    endcase
  end

  // A slot is free when empty, or when the held response leaves this cycle.
  assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
  assign w_accept     = ~rst & (|req_valid) & w_can_accept;
  assign req_ready    = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  assign w_op    = w_gnt ? req_op[3:2] : req_op[1:0];
  assign w_data  = w_gnt ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
  assign w_shamt = w_gnt ? req_shamt[2*SH_W-1:SH_W] : req_shamt[SH_W-1:0];
  assign w_tag   = w_gnt ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

  // Left shift is done as reverse -> right shift -> reverse.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign w_data_rev[i] = w_data[DATA_W-1-i];
    assign w_sh_h_rev[i] = w_sh_h[DATA_W-1-i];
  end

  // Map the requested op onto the right shifter's operand and fill bit.
  always_comb begin
    w_sh_b  = w_data;
    w_sh_ir = 1'b0;
    case (w_op)
      OP_SRA:  w_sh_ir = w_data[DATA_W-1];
      OP_SLL:  w_sh_b  = w_data_rev;
      default: begin
        w_sh_b  = w_data;
        w_sh_ir = 1'b0;
      end
    endcase
  end

  shift_right #(
    .W    (DATA_W),
    .SH_W (SH_W)
  ) u_shift_right (
    .i_b     (w_sh_b),
    .i_ir    (w_sh_ir),
    .i_shamt (w_shamt),
    .o_h     (w_sh_h)
  );

  // Select the final result; the illegal op returns zero with an error flag.
  always_comb begin
    w_result = w_sh_h;
    w_err    = 1'b0;
    case (w_op)
      OP_SLL:  w_result = w_sh_h_rev;
      OP_ILL: begin
        w_result = '0;
        w_err    = 1'b1;
      end
      default: w_result = w_sh_h;
    endcase
  end

  // Output stage: load on accept, drain on consumer ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= 1'b0;
    end else if (w_accept) begin
      r_state      <= ST_FULL;
      r_last_grant <= w_gnt;
      r_rsp_data   <= w_result;
      r_rsp_id     <= w_gnt;
      r_rsp_tag    <= w_tag;
      r_rsp_err    <= w_err;
    end else if ((r_state == ST_FULL) && rsp_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  // Valid is masked during reset so no response handshake completes that cycle.
  assign rsp_valid = (r_state == ST_FULL) & ~rst;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_err   = r_rsp_err;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] r_stat_grant0;
  logic [15:0] r_stat_grant1;
  logic [15:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = (r_state == ST_FULL) & ~rsp_ready & (|req_valid);

  // Saturating per-requester accept counters and a stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_grant0 <= '0;
      r_stat_grant1 <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_accept && !w_gnt && (r_stat_grant0 != '1))
        r_stat_grant0 <= r_stat_grant0 + 16'd1;
      if (w_accept && w_gnt && (r_stat_grant1 != '1))
        r_stat_grant1 <= r_stat_grant1 + 16'd1;
      if (w_stall && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_grant0 = r_stat_grant0;
  assign stat_grant1 = r_stat_grant1;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed, table-driven bench for shift_arbiter (DATA_W=32, TAG_W=4).
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_data;
  logic [9:0]  req_shamt;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] stat_grant0;
  logic [15:0] stat_grant1;
  logic [15:0] stat_stall;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  shift_arbiter #(
    .DATA_W (32),
    .TAG_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  sh;
    logic [3:0]  tag;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [3:0] tag);
    req_op[n*2 +: 2]    = op;
    req_data[n*32 +: 32] = d;
    req_shamt[n*5 +: 5] = sh;
    req_tag[n*4 +: 4]   = tag;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'h8000_0000, 5'd4,  4'h1, 32'h0800_0000, 1'b0};
    vecs[1]  = '{2'b01, 32'h8000_0000, 5'd4,  4'h2, 32'hF800_0000, 1'b0};
    vecs[2]  = '{2'b10, 32'h0000_0001, 5'd31, 4'h3, 32'h8000_0000, 1'b0};
    vecs[3]  = '{2'b10, 32'h1234_5678, 5'd0,  4'h4, 32'h1234_5678, 1'b0};
    vecs[4]  = '{2'b01, 32'h7FFF_FFFF, 5'd31, 4'h5, 32'h0000_0000, 1'b0};
    vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 5'd31, 4'h6, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{2'b00, 32'hDEAD_BEEF, 5'd8,  4'h7, 32'h00DE_ADBE, 1'b0};
    vecs[7]  = '{2'b10, 32'hDEAD_BEEF, 5'd8,  4'h8, 32'hADBE_EF00, 1'b0};
    vecs[8]  = '{2'b00, 32'hA5A5_A5A5, 5'd0,  4'h9, 32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{2'b01, 32'h8000_0001, 5'd1,  4'hA, 32'hC000_0000, 1'b0};
    vecs[10] = '{2'b10, 32'h8000_0001, 5'd1,  4'hB, 32'h0000_0002, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 5'd3,  4'h5, 32'h0000_0000, 1'b1};
    vecs[12] = '{2'b00, 32'h8000_0000, 5'd31, 4'hC, 32'h0000_0001, 1'b0};
    vecs[13] = '{2'b10, 32'h0000_000F, 5'd28, 4'hD, 32'hF000_0000, 1'b0};
    vecs[14] = '{2'b01, 32'h8000_0000, 5'd16, 4'hE, 32'hFFFF_8000, 1'b0};

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op = '0; req_data = '0; req_shamt = '0; req_tag = '0;

    // Reset for two cycles with both requesters asserting valid.
    tick(); tick();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

    // First grant after reset goes to requester 0; then requester 1 next cycle.
    set_req(0, 2'b00, 32'h8000_0000, 5'd4, 4'h1);
    set_req(1, 2'b01, 32'h8000_0000, 5'd4, 4'h2);
    rst = 1'b0; #1;
    chk("first_grant", {30'd0, req_ready}, 32'd1);
    tick();
    chk("srl_valid", {31'd0, rsp_valid}, 32'd1);
    chk("srl_data", rsp_data, 32'h0800_0000);
    chk("srl_id", {31'd0, rsp_id}, 32'd0);
    chk("srl_tag", {28'd0, rsp_tag}, 32'h1);
    req_valid = 2'b10; #1;
    chk("sra_ready", {30'd0, req_ready}, 32'd2);
    tick();
    chk("sra_data", rsp_data, 32'hF800_0000);
    chk("sra_id", {31'd0, rsp_id}, 32'd1);
    chk("sra_tag", {28'd0, rsp_tag}, 32'h2);

    // Round robin over six cycles of continuous contention.
    set_req(0, 2'b00, 32'h0000_0100, 5'd4, 4'hA);
    set_req(1, 2'b10, 32'h0000_0003, 5'd4, 4'hB);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rr_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_tag", {28'd0, rsp_tag}, (i % 2 == 0) ? 32'hA : 32'hB);
      chk("rr_data", rsp_data, (i % 2 == 0) ? 32'h10 : 32'h30);
    end
    req_valid = 2'b00;
    tick();
    chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: response held stable for three cycles, then back-to-back accept.
    set_req(0, 2'b00, 32'h0000_00F0, 5'd4, 4'h3);
    req_valid = 2'b01; rsp_ready = 1'b0; #1;
    chk("hold_first_ready", {30'd0, req_ready}, 32'd1);
    tick();
    chk("hold_first_data", rsp_data, 32'h0000_000F);
    set_req(0, 2'b01, 32'h8000_0000, 5'd1, 4'h4);
    set_req(1, 2'b00, 32'hFFFF_0000, 5'd16, 4'h6);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", {30'd0, req_ready}, 32'd0);
      tick();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, 32'h0000_000F);
      chk("hold_tag", {28'd0, rsp_tag}, 32'h3);
      chk("hold_id", {31'd0, rsp_id}, 32'd0);
    end
    rsp_ready = 1'b1; #1;
    chk("release_ready", {30'd0, req_ready}, 32'd2);
    tick();
    chk("release_data", rsp_data, 32'h0000_FFFF);
    chk("release_id", {31'd0, rsp_id}, 32'd1);
    chk("release_tag", {28'd0, rsp_tag}, 32'h6);
    req_valid = 2'b01; #1;
    chk("release2_ready", {30'd0, req_ready}, 32'd1);
    tick();
    chk("release2_data", rsp_data, 32'hC000_0000);
    chk("release2_tag", {28'd0, rsp_tag}, 32'h4);
    req_valid = 2'b00;
    tick();

    // Operation table, alternating requesters; the idle side carries decoy values.
    for (int i = 0; i < 15; i++) begin
      int n;
      n = i % 2;
      set_req(n, vecs[i].op, vecs[i].data, vecs[i].sh, vecs[i].tag);
      set_req(1 - n, 2'b11, ~vecs[i].data, vecs[i].sh + 5'd1, ~vecs[i].tag);
      req_valid = (n == 1) ? 2'b10 : 2'b01;
      #1;
      chk("tbl_ready", {30'd0, req_ready}, (n == 1) ? 32'd2 : 32'd1);
      tick();
      chk("tbl_data", rsp_data, vecs[i].exp);
      chk("tbl_err", {31'd0, rsp_err}, {31'd0, vecs[i].err});
      chk("tbl_id", {31'd0, rsp_id}, n);
      chk("tbl_tag", {28'd0, rsp_tag}, {28'd0, vecs[i].tag});
    end
    req_valid = 2'b00;
    tick();

    // Reset while a response is held drops it.
    set_req(0, 2'b00, 32'h0000_1234, 5'd0, 4'h7);
    req_valid = 2'b01; rsp_ready = 1'b0; #1;
    tick();
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("pre_rst_data", rsp_data, 32'h0000_1234);
    rst = 1'b1; #1;
    chk("mid_rst_ready", {30'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    rst = 1'b0; req_valid = 2'b00; #1;
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_data", rsp_data, 32'd0);
    chk("post_rst_tag", {28'd0, rsp_tag}, 32'd0);

`ifdef SHIFT_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("stat_g0_clr", {16'd0, stat_grant0}, 32'd0);
    chk("stat_stall_clr", {16'd0, stat_stall}, 32'd0);
    set_req(0, 2'b00, 32'h1, 5'd0, 4'h1);
    req_valid = 2'b01; rsp_ready = 1'b0;
    repeat (4) tick();
    chk("stat_stall_3", {16'd0, stat_stall}, 32'd3);
    chk("stat_g0_1", {16'd0, stat_grant0}, 32'd1);
    rsp_ready = 1'b1;
    repeat (70000) tick();
    chk("stat_g0_sat", {16'd0, stat_grant0}, 32'h0000_FFFF);
    chk("stat_g1_zero", {16'd0, stat_grant1}, 32'd0);
    chk("stat_stall_keep", {16'd0, stat_stall}, 32'd3);
    req_valid = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
